niosii_system_sysid_checker: RTL and testbench

NIOSII_SYSTEM_SYSID_CHECKER -- requirements
Module: niosII_system_sysid_checker

---
 rtl/niosii_system_sysid_checker.sv | 144 ++++++++++++++
 tb/tb_niosii_system_sysid_checker.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_sysid_checker.sv
// Reads the system ID and build timestamp words from a sysid slave, compares them with
// the expected build values and retries a bounded number of times on mismatch.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'h58ABBDA5,
  parameter int          READ_LATENCY = 1,
  parameter int          RETRY_MAX    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  attempts
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    COMPARE,
    DONE
  } state_t;

  localparam logic [2:0] WAIT_LOAD   = 3'(READ_LATENCY - 1);
  localparam logic [3:0] RETRY_LIMIT = 4'(RETRY_MAX);

  state_t     state;
  logic [2:0] wait_cnt;
  logic [3:0] retry_cnt;
  logic [1:0] mismatch;

  assign mismatch = {ts_value != EXPECTED_TS, id_value != EXPECTED_ID};

  // Outputs are registered: each transition sets the strobe/address/status for the state it enters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sysid_read    <= 1'b0;
      sysid_address <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      error_code    <= 2'b00;
      id_value      <= 32'd0;
      ts_value      <= 32'd0;
      attempts      <= 4'd0;
      wait_cnt      <= 3'd0;
      retry_cnt     <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RD_ID;
            sysid_read    <= 1'b1;
            sysid_address <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            error_code    <= 2'b00;
            attempts      <= 4'd0;
            retry_cnt     <= 4'd0;
          end
        end

        RD_ID: begin
          state      <= WAIT_ID;
          sysid_read <= 1'b0;
          wait_cnt   <= WAIT_LOAD;
        end

        WAIT_ID: begin
          if (wait_cnt == 3'd0) begin
            id_value      <= sysid_readdata;
            state         <= RD_TS;
            sysid_read    <= 1'b1;
            sysid_address <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        RD_TS: begin
          state      <= WAIT_TS;
          sysid_read <= 1'b0;
          wait_cnt   <= WAIT_LOAD;
        end

        WAIT_TS: begin
          if (wait_cnt == 3'd0) begin
            ts_value <= sysid_readdata;
            state    <= COMPARE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        // A retry restarts the whole ID/timestamp pass; attempts saturates rather than wrapping.
        COMPARE: begin
          if (attempts != 4'hF) begin
            attempts <= attempts + 4'd1;
          end
          if (mismatch == 2'b00) begin
            state         <= DONE;
            sysid_address <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            pass          <= 1'b1;
            error_code    <= 2'b00;
          end else if (retry_cnt < RETRY_LIMIT) begin
            retry_cnt     <= retry_cnt + 4'd1;
            state         <= RD_ID;
            sysid_read    <= 1'b1;
            sysid_address <= 1'b0;
          end else begin
            state         <= DONE;
            sysid_address <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            pass          <= 1'b0;
            error_code    <= mismatch;
          end
        end

        default: begin
          state         <= IDLE;
          sysid_read    <= 1'b0;
          sysid_address <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Self-checking bench for niosii_system_sysid_checker: table vectors, randomized slave
// responses against a pass-level model, and hand sequences for start/reset corner cases.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'h58ABBDA5;
  localparam int LAT   = 1;
  localparam int RETRY = 3;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        sysid_address;
  logic        sysid_read;
  logic [31:0] sysid_readdata;
  logic        busy, done, pass;
  logic [1:0]  error_code;
  logic [31:0] id_value, ts_value;
  logic [3:0]  attempts;

  logic        start3;
  logic        sysid_address3, sysid_read3;
  logic [31:0] sysid_readdata3;
  logic        busy3, done3, pass3;
  logic [1:0]  error_code3;
  logic [31:0] id_value3, ts_value3;
  logic [3:0]  attempts3;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] id_seq [16];
  logic [31:0] ts_seq [16];
  int id_reads, ts_reads, read_pulses, consec_reads, sched_err, cyc;
  logic prev_read;
  int read3_cycles [$];

  typedef struct {
    logic [31:0] id0, id_later, ts0, ts_later;
    logic        exp_pass;
    logic [1:0]  exp_err;
    int          exp_attempts, exp_edge, exp_reads;
  } vec_t;

  vec_t vecs [6];

  niosii_system_sysid_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .sysid_address(sysid_address), .sysid_read(sysid_read), .sysid_readdata(sysid_readdata),
    .busy(busy), .done(done), .pass(pass), .error_code(error_code),
    .id_value(id_value), .ts_value(ts_value), .attempts(attempts)
  );

  niosii_system_sysid_checker #(.READ_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .start(start3),
    .sysid_address(sysid_address3), .sysid_read(sysid_read3), .sysid_readdata(sysid_readdata3),
    .busy(busy3), .done(done3), .pass(pass3), .error_code(error_code3),
    .id_value(id_value3), .ts_value(ts_value3), .attempts(attempts3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave model: the n-th read of each address returns entry n-1 of its sequence.
  always_comb begin
    int i;
    i = sysid_address ? ts_reads : id_reads;
    if (i > 0) i = i - 1;
    if (i > 15) i = 15;
    sysid_readdata = sysid_address ? ts_seq[i] : id_seq[i];
  end

  assign sysid_readdata3 = sysid_address3 ? EXP_TS : EXP_ID;

  always @(posedge clock) begin
    cyc++;
    if (sysid_read) begin
      read_pulses++;
      if (sysid_address) ts_reads++;
      else id_reads++;
      if (prev_read) consec_reads++;
    end
    prev_read = sysid_read;
    if (sysid_read3) read3_cycles.push_back(cyc);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadSlave(input logic [31:0] id0, input logic [31:0] id_later,
                           input logic [31:0] ts0, input logic [31:0] ts_later);
    for (int i = 0; i < 16; i++) begin
      id_seq[i] = (i == 0) ? id0 : id_later;
      ts_seq[i] = (i == 0) ? ts0 : ts_later;
    end
  endtask

  // Pass-level model: each pass reads one ID/timestamp pair; stop on match or when retries run out.
  task automatic modelCheck(output logic exp_pass, output logic [1:0] exp_err, output int exp_att,
                            output int exp_edge, output int exp_reads,
                            output logic [31:0] exp_id, output logic [31:0] exp_ts);
    int p;
    logic [1:0] m;
    p = 0;
    forever begin
      m = {ts_seq[p] != EXP_TS, id_seq[p] != EXP_ID};
      if (m == 2'b00) begin
        exp_pass = 1'b1; exp_err = 2'b00; break;
      end
      if (p >= RETRY) begin
        exp_pass = 1'b0; exp_err = m; break;
      end
      p++;
    end
    exp_att   = (p + 1 > 15) ? 15 : p + 1;
    exp_edge  = (p + 1) * (2 * LAT + 3);
    exp_reads = 2 * (p + 1);
    exp_id    = id_seq[p];
    exp_ts    = ts_seq[p];
  endtask

  // Starts a check on the main DUT and watches the read/address schedule until done.
  task automatic applyStimulus(input bit hold, output int done_edge);
    int e, r, period;
    period = 2 * LAT + 3;
    @(negedge clock);
    read_pulses = 0; id_reads = 0; ts_reads = 0; sched_err = 0;
    start = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
    checkOutput("start_clears_attempts", 32'(attempts), 32'd0);
    done_edge = -1;
    for (e = 0; e < 300; e++) begin
      if (done) begin
        done_edge = e;
        break;
      end
      r = e % period;
      if (sysid_address !== (r >= LAT + 1) || sysid_read !== (r == 0 || r == LAT + 1) || busy !== 1'b1)
        sched_err++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkResult(input string tag, input logic exp_pass, input logic [1:0] exp_err,
                             input int exp_att, input int exp_edge, input int exp_reads,
                             input logic [31:0] exp_id, input logic [31:0] exp_ts, input int done_edge);
    checkOutput({tag, "_done_edge"}, 32'(done_edge), 32'(exp_edge));
    checkOutput({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    checkOutput({tag, "_error_code"}, 32'(error_code), 32'(exp_err));
    checkOutput({tag, "_attempts"}, 32'(attempts), 32'(exp_att));
    checkOutput({tag, "_read_pulses"}, 32'(read_pulses), 32'(exp_reads));
    checkOutput({tag, "_id_value"}, id_value, exp_id);
    checkOutput({tag, "_ts_value"}, ts_value, exp_ts);
    checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
    checkOutput({tag, "_addr_done"}, 32'(sysid_address), 32'd0);
    checkOutput({tag, "_schedule"}, 32'(sched_err), 32'd0);
  endtask

  initial begin
    int de, c0, gap;
    logic ep;
    logic [1:0] ee;
    int ea, eg, er;
    logic [31:0] eid, ets;

    vecs[0] = '{EXP_ID, EXP_ID, EXP_TS, EXP_TS, 1'b1, 2'b00, 1, 5, 2};
    vecs[1] = '{EXP_ID, EXP_ID, 32'h58ABBDA4, 32'h58ABBDA4, 1'b0, 2'b10, 4, 20, 8};
    vecs[2] = '{32'h1, EXP_ID, EXP_TS, EXP_TS, 1'b1, 2'b00, 2, 10, 4};
    vecs[3] = '{32'h5, 32'h5, 32'h0, 32'h0, 1'b0, 2'b11, 4, 20, 8};
    vecs[4] = '{32'h7, 32'h7, EXP_TS, EXP_TS, 1'b0, 2'b01, 4, 20, 8};
    vecs[5] = '{EXP_ID, EXP_ID, 32'hDEADBEEF, EXP_TS, 1'b1, 2'b00, 2, 10, 4};

    cyc = 0; read_pulses = 0; id_reads = 0; ts_reads = 0; consec_reads = 0; prev_read = 1'b0;
    reset_n = 1'b0; start = 1'b0; start3 = 1'b0;
    loadSlave(EXP_ID, EXP_ID, EXP_TS, EXP_TS);

    #23;
    checkOutput("reset_read", 32'(sysid_read), 32'd0);
    checkOutput("reset_addr", 32'(sysid_address), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_pass", 32'(pass), 32'd0);
    checkOutput("reset_error_code", 32'(error_code), 32'd0);
    checkOutput("reset_attempts", 32'(attempts), 32'd0);
    checkOutput("reset_id_value", id_value, 32'd0);
    checkOutput("reset_ts_value", ts_value, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("idle_no_reads", 32'(read_pulses), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) begin
      loadSlave(vecs[v].id0, vecs[v].id_later, vecs[v].ts0, vecs[v].ts_later);
      applyStimulus(1'b0, de);
      checkResult($sformatf("vec%0d", v), vecs[v].exp_pass, vecs[v].exp_err, vecs[v].exp_attempts,
                  vecs[v].exp_edge, vecs[v].exp_reads,
                  (vecs[v].exp_attempts == 1) ? vecs[v].id0 : vecs[v].id_later,
                  (vecs[v].exp_attempts == 1) ? vecs[v].ts0 : vecs[v].ts_later, de);
    end

    for (int t = 0; t < 20; t++) begin
      for (int p = 0; p < 16; p++) begin
        id_seq[p] = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
        ts_seq[p] = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      end
      modelCheck(ep, ee, ea, eg, er, eid, ets);
      applyStimulus(1'b0, de);
      checkResult($sformatf("rand%0d", t), ep, ee, ea, eg, er, eid, ets, de);
    end

    // start held high: first check completes, then restarts on the next edge.
    loadSlave(EXP_ID, EXP_ID, EXP_TS, EXP_TS);
    applyStimulus(1'b1, de);
    checkOutput("held_done_edge", 32'(de), 32'd5);
    checkOutput("held_pass", 32'(pass), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("held_restart_done", 32'(done), 32'd0);
    checkOutput("held_restart_busy", 32'(busy), 32'd1);
    checkOutput("held_restart_attempts", 32'(attempts), 32'd0);
    start = 1'b0;
    de = -1;
    for (int e = 0; e < 50; e++) begin
      @(posedge clock);
      #1;
      if (done) begin de = e; break; end
    end
    checkOutput("held_second_done", 32'(de >= 0), 32'd1);
    checkOutput("held_second_pass", 32'(pass), 32'd1);

    // start pulsed while busy is neither queued nor restarts the check.
    @(negedge clock);
    read_pulses = 0; id_reads = 0; ts_reads = 0;
    start = 1'b1;
    @(posedge clock);
    #1;
    c0 = cyc;
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    de = -1;
    for (int e = 0; e < 50; e++) begin
      if (done) begin de = cyc - c0; break; end
      @(posedge clock);
      #1;
    end
    checkOutput("busy_start_done_edge", 32'(de), 32'd5);
    repeat (10) @(posedge clock);
    #1;
    checkOutput("busy_start_reads", 32'(read_pulses), 32'd2);
    checkOutput("busy_start_done_held", 32'(done), 32'd1);
    checkOutput("busy_start_idle", 32'(busy), 32'd0);

    // Reset during WAIT_TS aborts the check and clears everything at once.
    loadSlave(32'h1234, 32'h1234, EXP_TS, EXP_TS);
    @(negedge clock);
    read_pulses = 0; id_reads = 0; ts_reads = 0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checkOutput("pre_reset_id_value", id_value, 32'h1234);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_read", 32'(sysid_read), 32'd0);
    checkOutput("midreset_addr", 32'(sysid_address), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_pass", 32'(pass), 32'd0);
    checkOutput("midreset_error_code", 32'(error_code), 32'd0);
    checkOutput("midreset_attempts", 32'(attempts), 32'd0);
    checkOutput("midreset_id_value", id_value, 32'd0);
    checkOutput("midreset_ts_value", ts_value, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    read_pulses = 0;
    repeat (20) @(posedge clock);
    #1;
    checkOutput("post_reset_reads", 32'(read_pulses), 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("post_reset_done", 32'(done), 32'd0);

    // READ_LATENCY=3 instance with a matching slave.
    @(negedge clock);
    read3_cycles.delete();
    start3 = 1'b1;
    @(posedge clock);
    #1;
    c0 = cyc;
    start3 = 1'b0;
    de = -1;
    for (int e = 0; e < 100; e++) begin
      if (done3) begin de = cyc - c0; break; end
      @(posedge clock);
      #1;
    end
    gap = (read3_cycles.size() >= 2) ? (read3_cycles[1] - read3_cycles[0]) : -1;
    checkOutput("lat3_done_edge", 32'(de), 32'd9);
    checkOutput("lat3_read_count", 32'(read3_cycles.size()), 32'd2);
    checkOutput("lat3_read_gap", 32'(gap), 32'd4);
    checkOutput("lat3_pass", 32'(pass3), 32'd1);
    checkOutput("lat3_error_code", 32'(error_code3), 32'd0);
    checkOutput("lat3_ts_value", ts_value3, EXP_TS);

    checkOutput("no_back_to_back_reads", 32'(consec_reads), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
